// File: rtl/dram_burst_pkg.sv
// Shared definitions for the dram_burst pixel memory.
//   - FSM state encoding (IDLE, RD, WR)
//   - frame geometry and the default memory depth derived from it
package dram_burst_pkg;

  localparam int FRAME_W       = 640;
  localparam int FRAME_H       = 480;
  localparam int DEFAULT_DEPTH = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

endpackage : dram_burst_pkg

// File: rtl/dram_burst_if.sv
// Command / write-beat / read-beat bundle of the dram_burst pixel memory.
//   master : the requester (processor memory stage or testbench)
//   slave  : the dram_burst block
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_len/req_stride  burst command
//   wr_data/wr_valid/wr_ready                                  write beats
//   rd_data/rd_valid/rd_ready                                  read beats
//   busy, err                                                  status
interface dram_burst_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 19,
  parameter int LEN_W    = 10,
  parameter int STRIDE_W = 4
) ();

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [LEN_W-1:0]    req_len;
  logic [STRIDE_W-1:0] req_stride;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                busy;
  logic                err;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_stride,
    output wr_data, wr_valid, rd_ready,
    input  req_ready, wr_ready, rd_data, rd_valid, busy, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_stride,
    input  wr_data, wr_valid, rd_ready,
    output req_ready, wr_ready, rd_data, rd_valid, busy, err
  );

endinterface : dram_burst_if

// File: rtl/dram_burst_core.sv
// Single-port synchronous pixel RAM with registered read.
// Ports:
//   clk    system clock
//   we     write enable (takes priority over re)
//   re     read enable; rdata updates only when re is high, otherwise holds
//   addr   word address, must be < DEPTH whenever we or re is high
//   wdata  write data
//   rdata  registered read data
module dram_core
  import dram_burst_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; a reset loop over
  // a frame-sized array cannot map onto RAM macros, and contents must
  // survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule : dram_core

// File: rtl/dram_burst.sv
// Burst-capable pixel data RAM for the image downsampling datapath.
// Accepts a command (address, length, stride), then streams write beats into
// or read beats out of dram_core, advancing the address by the stride each
// beat. Out-of-range beats are dropped (write) or return 0 (read) and set the
// sticky err flag, which clears on the next accepted command.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dram_burst_if slave: command, write beats, read beats, busy, err
module dram_burst
  import dram_burst_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 19,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int LEN_W    = 10,
  parameter int STRIDE_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dram_burst_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_WR   = WR;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_zero_q, rd_zero_d;
  logic                err_q, err_d;

  logic                req_ready;
  logic                in_range;
  logic                issue;
  logic                wr_fire;
  logic                last_beat;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   core_rdata;

  // A new command waits until the final read beat of the previous burst has
  // been consumed, so bursts never overlap on the read port.
  assign req_ready = (state_q == S_IDLE) && !rd_valid_q;
  assign in_range  = {1'b0, cur_addr_q} < DEPTH_L;
  assign issue     = (state_q == S_RD) && (!rd_valid_q || bus.rd_ready);
  assign wr_fire   = (state_q == S_WR) && bus.wr_valid;
  assign last_beat = (beats_left_q == '0);
  // Address wraps modulo 2**ADDR_W by truncation.
  assign next_addr = cur_addr_q + ADDR_W'(stride_q);

  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    stride_d     = stride_q;
    rd_valid_d   = rd_valid_q;
    rd_zero_d    = rd_zero_q;
    err_d        = err_q;

    if (bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          cur_addr_d   = bus.req_addr;
          beats_left_d = bus.req_len;
          stride_d     = bus.req_stride;
          err_d        = 1'b0;
          state_d      = bus.req_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (wr_fire) begin
          if (!in_range) err_d = 1'b1;
          cur_addr_d   = next_addr;
          beats_left_d = beats_left_q - LEN_W'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (issue) begin
          rd_valid_d   = 1'b1;
          rd_zero_d    = !in_range;
          if (!in_range) err_d = 1'b1;
          cur_addr_d   = next_addr;
          beats_left_d = beats_left_q - LEN_W'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      stride_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      stride_q     <= stride_d;
      rd_valid_q   <= rd_valid_d;
      rd_zero_q    <= rd_zero_d;
      err_q        <= err_d;
    end
  end

  // The RAM read register doubles as the output data register: it only
  // loads on an in-range issue, so it holds while the consumer stalls.
  // rd_zero_q forces 0 after reset and for out-of-range beats.
  dram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .we    (wr_fire && in_range),
    .re    (issue && in_range),
    .addr  (cur_addr_q),
    .wdata (bus.wr_data),
    .rdata (core_rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.wr_ready  = (state_q == S_WR);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_zero_q ? '0 : core_rdata;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;

endmodule : dram_burst
